// File: rtl/ddr_traffic_checker.sv
// ddr_traffic_checker: DDR burst write / read-back / compare engine
// driving the bd_wrap datamover request, data and response channels.
module ddr_traffic_checker #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          SIZE_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 64,
  parameter int          BURST_BEATS = 256,
  parameter int          ERR_WIDTH   = 8,
  parameter logic [31:0] LFSR_SEED   = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_en,
  input  logic [1:0]            test_mode,
  input  logic                  test_loop,
  input  logic [ADDR_WIDTH-1:0] test_addr,
  input  logic [15:0]           test_size,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [15:0]           pass_cnt,
  output logic [ERR_WIDTH-1:0]  data_err_cnt,
  output logic [ERR_WIDTH-1:0]  resp_err_cnt,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  wreq_ready,
  output logic                  wreq_valid,
  output logic [ADDR_WIDTH-1:0] wreq_addr,
  output logic [SIZE_WIDTH-1:0] wreq_size,
  input  logic                  wdata_ready,
  output logic                  wdata_valid,
  output logic                  wdata_last,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wresp_valid,
  input  logic [1:0]            wresp,
  input  logic                  rreq_ready,
  output logic                  rreq_valid,
  output logic [ADDR_WIDTH-1:0] rreq_addr,
  output logic [SIZE_WIDTH-1:0] rreq_size,
  output logic                  rdata_ready,
  input  logic                  rdata_valid,
  input  logic                  rdata_last,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rresp_valid,
  input  logic [1:0]            rresp
);

  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int NW = DATA_WIDTH / 32;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [1:0] M_INC  = 2'd0;
  localparam logic [1:0] M_LFSR = 2'd1;
  localparam logic [1:0] M_WALK = 2'd2;
  localparam logic [1:0] M_TOG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WREQ, S_WDATA, S_WRESP,
    S_RREQ, S_RDATA, S_RRESP, S_NEXT
  } state_e;

  state_e                state_q, state_d;
  logic                  en_q;
  logic [1:0]            mode_q, mode_d;
  logic                  loop_q, loop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [ADDR_WIDTH-1:0] erra_q, erra_d;
  logic [15:0]           size_q, size_d;
  logic [15:0]           burst_q, burst_d;
  logic [15:0]           pass_q, pass_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abrt_q, abrt_d;
  logic                  abtd_q, abtd_d;
  logic                  errv_q, errv_d;
  logic [ERR_WIDTH-1:0]  derr_q, derr_d;
  logic [ERR_WIDTH-1:0]  rerr_q, rerr_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] pat;
  logic [31:0]           word;
  logic [31:0]           walk_sh;
  logic                  is_last;
  logic                  start;
  logic [31:0]           seed;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(
    input logic [ERR_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign beat_addr = baddr_q + ADDR_WIDTH'(beat_q) * BEAT_INC;
  assign walk_sh = 32'(beat_q) % 32'(DATA_WIDTH);
  assign is_last = (beat_q == LAST_BEAT);
  assign start = (state_q == S_IDLE) && test_en && !en_q;
  assign seed = LFSR_SEED ^ 32'(burst_q);

  // Regenerate the pattern beat for write data and read compare
  always_comb begin
    word = 32'h0;
    unique case (mode_q)
      M_INC:   word = 32'(beat_addr);
      M_LFSR:  word = lfsr_q;
      M_TOG:   word = beat_q[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      default: word = 32'h0;
    endcase
    pat = {NW{word}};
    if (mode_q == M_WALK) pat = ONE << walk_sh;
  end

  // Next-state and datapath updates for the burst sequencer
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    loop_d  = loop_q;
    addr_d  = addr_q;
    size_d  = size_q;
    baddr_d = baddr_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    lfsr_d  = lfsr_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abrt_d  = abrt_q;
    abtd_d  = abtd_q;
    errv_d  = errv_q;
    erra_d  = erra_q;
    derr_d  = derr_q;
    rerr_d  = rerr_q;
    if (busy_q && !test_en) abrt_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (start) begin
        mode_d  = test_mode;
        loop_d  = test_loop;
        addr_d  = test_addr;
        size_d  = test_size;
        baddr_d = test_addr;
        burst_d = '0;
        pass_d  = '0;
        derr_d  = '0;
        rerr_d  = '0;
        errv_d  = 1'b0;
        erra_d  = '0;
        abtd_d  = 1'b0;
        abrt_d  = 1'b0;
        if (test_size == 16'd0) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b1;
          state_d = S_WREQ;
        end
      end
      S_WREQ: begin
        lfsr_d = seed;
        beat_d = '0;
        if (wreq_ready) state_d = S_WDATA;
      end
      S_WDATA: if (wdata_ready) begin
        beat_d = beat_q + 1'b1;
        lfsr_d = lfsr_step(lfsr_q);
        if (is_last) state_d = S_WRESP;
      end
      S_WRESP: if (wresp_valid) begin
        if (wresp != 2'd0) rerr_d = sat_inc(rerr_q);
        state_d = S_RREQ;
      end
      S_RREQ: begin
        lfsr_d = seed;
        beat_d = '0;
        if (rreq_ready) state_d = S_RDATA;
      end
      S_RDATA: if (rdata_valid) begin
        if (rdata != pat) begin
          derr_d = sat_inc(derr_q);
          if (!errv_q) begin
            errv_d = 1'b1;
            erra_d = beat_addr;
          end
        end
        if (rdata_last != is_last) rerr_d = sat_inc(rerr_q);
        beat_d = beat_q + 1'b1;
        lfsr_d = lfsr_step(lfsr_q);
        if (is_last) state_d = S_RRESP;
      end
      S_RRESP: if (rresp_valid) begin
        if (rresp != 2'd0) rerr_d = sat_inc(rerr_q);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (abrt_q || !test_en) begin
          abtd_d  = 1'b1;
          abrt_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (burst_q == size_q - 16'd1) begin
          pass_d = pass_q + 16'd1;
          done_d = 1'b1;
          if (loop_q) begin
            burst_d = '0;
            baddr_d = addr_q;
            state_d = S_WREQ;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          burst_d = burst_q + 16'd1;
          baddr_d = baddr_q + BURST_INC;
          state_d = S_WREQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath, counters and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      mode_q  <= '0;
      loop_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      baddr_q <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      lfsr_q  <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      abtd_q  <= 1'b0;
      errv_q  <= 1'b0;
      erra_q  <= '0;
      derr_q  <= '0;
      rerr_q  <= '0;
    end else begin
      en_q    <= test_en;
      mode_q  <= mode_d;
      loop_q  <= loop_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      baddr_q <= baddr_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      lfsr_q  <= lfsr_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      abtd_q  <= abtd_d;
      errv_q  <= errv_d;
      erra_q  <= erra_d;
      derr_q  <= derr_d;
      rerr_q  <= rerr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = abtd_q;
  assign pass_cnt     = pass_q;
  assign data_err_cnt = derr_q;
  assign resp_err_cnt = rerr_q;
  assign err_valid    = errv_q;
  assign err_addr     = erra_q;
  assign wreq_valid   = (state_q == S_WREQ);
  assign wreq_addr    = baddr_q;
  assign wreq_size    = SIZE_WIDTH'(BURST_BYTES);
  assign wdata_valid  = (state_q == S_WDATA);
  assign wdata_last   = wdata_valid && is_last;
  assign wdata        = pat;
  assign rreq_valid   = (state_q == S_RREQ);
  assign rreq_addr    = baddr_q;
  assign rreq_size    = SIZE_WIDTH'(BURST_BYTES);
  assign rdata_ready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// tb_ddr_traffic_checker: datamover slave model with expected-data
// queues for ddr_traffic_checker.
module tb_ddr_traffic_checker;

  localparam logic [31:0] BURST_B = 32'd2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_en;
  logic [1:0]  test_mode;
  logic        test_loop;
  logic [31:0] test_addr;
  logic [15:0] test_size;
  logic        busy, done, aborted;
  logic [15:0] pass_cnt;
  logic [7:0]  data_err_cnt, resp_err_cnt;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        wreq_ready, wreq_valid;
  logic [31:0] wreq_addr;
  logic [15:0] wreq_size;
  logic        wdata_ready, wdata_valid, wdata_last;
  logic [63:0] wdata;
  logic        wresp_valid;
  logic [1:0]  wresp;
  logic        rreq_ready, rreq_valid;
  logic [31:0] rreq_addr;
  logic [15:0] rreq_size;
  logic        rdata_ready, rdata_valid, rdata_last;
  logic [63:0] rdata;
  logic        rresp_valid;
  logic [1:0]  rresp;

  ddr_traffic_checker #(
    .ADDR_WIDTH(32), .SIZE_WIDTH(16), .DATA_WIDTH(64),
    .BURST_BEATS(256), .ERR_WIDTH(8), .LFSR_SEED(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .test_en(test_en),
    .test_mode(test_mode), .test_loop(test_loop),
    .test_addr(test_addr), .test_size(test_size),
    .busy(busy), .done(done), .aborted(aborted),
    .pass_cnt(pass_cnt), .data_err_cnt(data_err_cnt),
    .resp_err_cnt(resp_err_cnt), .err_valid(err_valid),
    .err_addr(err_addr),
    .wreq_ready(wreq_ready), .wreq_valid(wreq_valid),
    .wreq_addr(wreq_addr), .wreq_size(wreq_size),
    .wdata_ready(wdata_ready), .wdata_valid(wdata_valid),
    .wdata_last(wdata_last), .wdata(wdata),
    .wresp_valid(wresp_valid), .wresp(wresp),
    .rreq_ready(rreq_ready), .rreq_valid(rreq_valid),
    .rreq_addr(rreq_addr), .rreq_size(rreq_size),
    .rdata_ready(rdata_ready), .rdata_valid(rdata_valid),
    .rdata_last(rdata_last), .rdata(rdata),
    .rresp_valid(rresp_valid), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_wq[$];
  logic [31:0] exp_waq[$];
  logic [31:0] exp_raq[$];
  logic [63:0] mem [logic [31:0]];

  bit stall = 0;
  bit flip5 = 0;
  bit flipall = 0;
  bit wresp_once = 0;
  bit early_once = 0;
  int rburst = 0;
  int done_cnt = 0;
  int wreq_cnt = 0;

  function automatic logic [31:0] lstep(input logic [31:0] v);
    lstep = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic bit rnd();
    return stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // write-channel slave: accepts requests/data, stores beats, responds
  initial begin : wr_slave
    logic [31:0] wbase;
    int wbeat;
    bit wpend, held;
    logic [63:0] hold;
    wreq_ready = 0; wdata_ready = 0; wresp_valid = 0; wresp = 0;
    wbase = 0; wbeat = 0; wpend = 0; held = 0; hold = 0;
    forever begin
      @(negedge clk);
      wresp_valid = 0;
      wresp = 0;
      if (held && wdata_valid) chk("wdata_stable", wdata, hold);
      held = 0;
      if (wpend && rnd()) begin
        wresp_valid = 1;
        wresp = wresp_once ? 2'd2 : 2'd0;
        wresp_once = 0;
        wpend = 0;
      end
      wdata_ready = rnd();
      if (wdata_valid && wdata_ready) begin
        if (exp_wq.size() == 0) chk("wq_under", 1, 0);
        else chk("wdata", wdata, exp_wq.pop_front());
        mem[wbase + 32'(wbeat) * 32'd8] = wdata;
        wbeat++;
        chk("wlast", wdata_last, wbeat == 256);
        if (wbeat == 256) wpend = 1;
      end else if (wdata_valid) begin
        held = 1;
        hold = wdata;
      end
      wreq_ready = rnd();
      if (wreq_valid && wreq_ready) begin
        if (exp_waq.size() == 0) chk("waq_under", 1, 0);
        else chk("wreq_addr", wreq_addr, exp_waq.pop_front());
        chk("wreq_size", wreq_size, 16'd2048);
        wbase = wreq_addr;
        wbeat = 0;
      end
    end
  end

  // read-channel slave: returns stored beats with optional faults
  initial begin : rd_slave
    logic [31:0] rbase, a;
    int rbeat;
    bit ract, rpend;
    logic [63:0] d;
    rreq_ready = 0; rdata_valid = 0; rdata_last = 0; rdata = 0;
    rresp_valid = 0; rresp = 0;
    rbase = 0; rbeat = 0; ract = 0; rpend = 0;
    forever begin
      @(negedge clk);
      rresp_valid = 0;
      if (rpend && rnd()) begin
        rresp_valid = 1;
        rpend = 0;
      end
      if (ract) begin
        rdata_valid = rnd();
        a = rbase + 32'(rbeat) * 32'd8;
        d = mem.exists(a) ? mem[a] : 64'h0;
        if (flipall || (flip5 && rburst == 1 && rbeat == 5))
          d[0] = ~d[0];
        rdata = d;
        rdata_last = (rbeat == 255) || (early_once && rbeat == 100);
        if (rdata_valid && rdata_ready) begin
          if (rbeat == 100) early_once = 0;
          rbeat++;
          if (rbeat == 256) begin
            ract = 0;
            rpend = 1;
          end
        end
      end else begin
        rdata_valid = 0;
        rdata_last = 0;
      end
      rreq_ready = rnd();
      if (rreq_valid && rreq_ready) begin
        if (exp_raq.size() == 0) chk("raq_under", 1, 0);
        else chk("rreq_addr", rreq_addr, exp_raq.pop_front());
        chk("rreq_size", rreq_size, 16'd2048);
        rbase = rreq_addr;
        rbeat = 0;
        ract = 1;
        rburst++;
      end
    end
  end

  // count done pulses and cycles with a write request presented
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (wreq_valid) wreq_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic push_run(input logic [1:0] m, input logic [31:0] a,
                          input int size, input int passes);
    logic [31:0] ba, bea, lf;
    logic [63:0] d;
    for (int p = 0; p < passes; p++) begin
      for (int b = 0; b < size; b++) begin
        ba = a + 32'(b) * BURST_B;
        exp_waq.push_back(ba);
        exp_raq.push_back(ba);
        lf = 32'h1 ^ 32'(b);
        for (int k = 0; k < 256; k++) begin
          bea = ba + 32'(k) * 32'd8;
          case (m)
            2'd0:    d = {bea, bea};
            2'd1:    d = {lf, lf};
            2'd2:    d = 64'd1 << (k % 64);
            default: d = (k % 2 == 1) ? 64'hAAAA_AAAA_AAAA_AAAA
                                      : 64'h5555_5555_5555_5555;
          endcase
          exp_wq.push_back(d);
          lf = lstep(lf);
        end
      end
    end
  endtask

  task automatic start(input logic [1:0] m, input bit lp,
                       input logic [31:0] a, input int size);
    test_mode = m;
    test_loop = lp;
    test_addr = a;
    test_size = 16'(size);
    test_en = 1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", busy, 0);
    test_en = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_wq_left"}, exp_wq.size(), 0);
    chk({tag, "_raq_left"}, exp_raq.size(), 0);
  endtask

  int dc, dw, n;

  initial begin
    rst = 1; test_en = 0; test_mode = 0; test_loop = 0;
    test_addr = 0; test_size = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_derr", data_err_cnt, 0);
    chk("rst_rerr", resp_err_cnt, 0);
    chk("rst_errv", err_valid, 0);
    chk("rst_erra", err_addr, 0);
    chk("rst_wreqv", wreq_valid, 0);
    chk("rst_rrdy", rdata_ready, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // INC, two bursts, ideal slave
    push_run(2'd0, 32'h1000_0000, 2, 1);
    dc = done_cnt;
    start(2'd0, 0, 32'h1000_0000, 2);
    chk("inc_lat_wreq", wreq_valid, 1);
    chk("inc_busy", busy, 1);
    wait_idle(5000);
    chk("inc_done", done_cnt - dc, 1);
    chk("inc_pass", pass_cnt, 1);
    chk("inc_derr", data_err_cnt, 0);
    chk("inc_rerr", resp_err_cnt, 0);
    chk("inc_errv", err_valid, 0);
    chk_empty("inc");

    // LFSR with one flipped bit on beat 5 of burst 0
    flip5 = 1;
    rburst = 0;
    push_run(2'd1, 32'h2000_0000, 2, 1);
    start(2'd1, 0, 32'h2000_0000, 2);
    wait_idle(5000);
    flip5 = 0;
    chk("lfsr_derr", data_err_cnt, 1);
    chk("lfsr_errv", err_valid, 1);
    chk("lfsr_erra", err_addr, 32'h2000_0028);
    chk("lfsr_rerr", resp_err_cnt, 0);
    chk_empty("lfsr");

    // TOGGLE with random stalls on every channel
    stall = 1;
    push_run(2'd3, 32'h3000_0000, 4, 1);
    dc = done_cnt;
    start(2'd3, 0, 32'h3000_0000, 4);
    wait_idle(30000);
    stall = 0;
    chk("tog_done", done_cnt - dc, 1);
    chk("tog_derr", data_err_cnt, 0);
    chk("tog_rerr", resp_err_cnt, 0);
    chk("tog_pass", pass_cnt, 1);
    chk_empty("tog");

    // WALK1 with one bad wresp and one early rdata_last
    wresp_once = 1;
    early_once = 1;
    push_run(2'd2, 32'h0800_0000, 2, 1);
    start(2'd2, 0, 32'h0800_0000, 2);
    wait_idle(5000);
    chk("resp_rerr", resp_err_cnt, 2);
    chk("resp_derr", data_err_cnt, 0);
    chk("resp_errv", err_valid, 0);
    chk("resp_pass", pass_cnt, 1);
    chk_empty("resp");

    // loop mode aborted during write data of pass 3
    push_run(2'd0, 32'h4000_0000, 1, 3);
    dc = done_cnt;
    start(2'd0, 1, 32'h4000_0000, 1);
    n = 0;
    while (!(pass_cnt == 16'd2 && wdata_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("loop_reach_p3", pass_cnt == 16'd2 && wdata_valid, 1);
    repeat (20) @(negedge clk);
    test_en = 0;
    wait_idle(5000);
    chk("loop_abort", aborted, 1);
    chk("loop_pass", pass_cnt, 2);
    chk("loop_done", done_cnt - dc, 2);
    chk("loop_derr", data_err_cnt, 0);
    chk_empty("loop");

    // zero-size run: done pulse only, no requests
    dc = done_cnt;
    dw = wreq_cnt;
    start(2'd0, 0, 32'h5000_0000, 0);
    chk("sz0_done_n1", done, 1);
    chk("sz0_abort_clr", aborted, 0);
    @(negedge clk);
    chk("sz0_done_off", done, 0);
    repeat (5) @(negedge clk);
    chk("sz0_no_wreq", wreq_cnt - dw, 0);
    chk("sz0_done_cnt", done_cnt - dc, 1);
    test_en = 0;
    repeat (2) @(negedge clk);

    // every beat wrong, address wrapping past 2**32
    flipall = 1;
    push_run(2'd0, 32'hFFFF_F800, 2, 1);
    start(2'd0, 0, 32'hFFFF_F800, 2);
    wait_idle(5000);
    flipall = 0;
    chk("sat_derr", data_err_cnt, 8'd255);
    chk("sat_erra", err_addr, 32'hFFFF_F800);
    chk("sat_errv", err_valid, 1);
    chk("sat_rerr", resp_err_cnt, 0);
    chk_empty("sat");

    // reset clears accumulated state
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst2_derr", data_err_cnt, 0);
    chk("rst2_errv", err_valid, 0);
    chk("rst2_pass", pass_cnt, 0);
    rst = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
